// File: rtl/awsf1_pcis_pkg.sv
// Shared types and helpers for the PCIS AXI4 responder.
package awsf1_pcis_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } wr_state_t;

    typedef enum logic {
        RIdle,
        RData
    } rd_state_t;

    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/awsf1_pcis_bram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, read-first.
module awsf1_pcis_bram
    import awsf1_pcis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports update with non-blocking assignments, so a same-word read sees old data.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/awsf1_pcis_responder.sv
// AXI4 responder on the shell DMA PCIS port, backed by an on-chip buffer.
module awsf1_pcis_responder
    import awsf1_pcis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                    clk_main_a0,
    input  logic                    rst_main_n,
    input  logic [ID_WIDTH-1:0]     pcis_awid,
    input  logic [63:0]             pcis_awaddr,
    input  logic [7:0]              pcis_awlen,
    input  logic                    pcis_awvalid,
    output logic                    pcis_awready,
    input  logic [DATA_WIDTH-1:0]   pcis_wdata,
    input  logic [DATA_WIDTH/8-1:0] pcis_wstrb,
    input  logic                    pcis_wlast,
    input  logic                    pcis_wvalid,
    output logic                    pcis_wready,
    output logic [ID_WIDTH-1:0]     pcis_bid,
    output logic [1:0]              pcis_bresp,
    output logic                    pcis_bvalid,
    input  logic                    pcis_bready,
    input  logic [ID_WIDTH-1:0]     pcis_arid,
    input  logic [63:0]             pcis_araddr,
    input  logic [7:0]              pcis_arlen,
    input  logic                    pcis_arvalid,
    output logic                    pcis_arready,
    output logic [ID_WIDTH-1:0]     pcis_rid,
    output logic [DATA_WIDTH-1:0]   pcis_rdata,
    output logic [1:0]              pcis_rresp,
    output logic                    pcis_rlast,
    output logic                    pcis_rvalid,
    input  logic                    pcis_rready,
    output logic                    protocol_err
);

    localparam int unsigned ALSB = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned WAW  = 64 - ALSB;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{pcis_awaddr[ALSB-1:0], pcis_araddr[ALSB-1:0]};

    // Holds the ready outputs low for the first cycle out of reset.
    logic active_q;
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) active_q <= 1'b0;
        else             active_q <= 1'b1;
    end

    // ---------------- write side ----------------
    wr_state_t           wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0] bid_q;
    logic [WAW-1:0]      wword_q;
    logic [7:0]          wlen_q, wcnt_q;
    resp_t               bresp_q;
    logic                protocol_err_q;
    logic                aw_hs, w_hs, w_final, w_in_range;

    assign pcis_awready = active_q && (wr_state_q == WIdle);
    assign pcis_wready  = (wr_state_q == WData);
    assign pcis_bvalid  = (wr_state_q == WResp);
    assign pcis_bid     = bid_q;
    assign pcis_bresp   = bresp_q;
    assign protocol_err = protocol_err_q;

    assign aw_hs      = pcis_awvalid && pcis_awready;
    assign w_hs       = pcis_wvalid && pcis_wready;
    assign w_final    = (wcnt_q == wlen_q);
    assign w_in_range = (wword_q[WAW-1:IDXW] == '0);

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WIdle:   if (aw_hs) wr_state_d = WData;
            WData:   if (w_hs && w_final) wr_state_d = WResp;
            WResp:   if (pcis_bready) wr_state_d = WIdle;
            default: wr_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_state_q     <= WIdle;
            bid_q          <= '0;
            wword_q        <= '0;
            wlen_q         <= '0;
            wcnt_q         <= '0;
            bresp_q        <= RespOkay;
            protocol_err_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) begin
                bid_q   <= pcis_awid;
                wword_q <= pcis_awaddr[63:ALSB];
                wlen_q  <= pcis_awlen;
                wcnt_q  <= '0;
                bresp_q <= RespOkay;
            end
            if (w_hs) begin
                wword_q <= wword_q + WAW'(1);
                wcnt_q  <= wcnt_q + 8'd1;
                if (!w_in_range)            bresp_q        <= RespSlverr;
                if (pcis_wlast != w_final)  protocol_err_q <= 1'b1;
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_t             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [WAW-1:0]        rword_q;
    logic [7:0]            rlen_q;
    logic [8:0]            issue_cnt_q;
    logic                  inflight_q, inflight_oor_q, inflight_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    resp_t                 fifo_resp_q [2];
    logic                  fifo_last_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [2:0]            occ;
    logic                  ar_hs, pop, issue, r_in_range;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign pcis_arready = active_q && (rd_state_q == RIdle);
    assign pcis_rvalid  = (fifo_cnt_q != 2'd0);
    assign pcis_rid     = rid_q;
    assign pcis_rdata   = fifo_data_q[rd_ptr_q];
    assign pcis_rresp   = fifo_resp_q[rd_ptr_q];
    assign pcis_rlast   = fifo_last_q[rd_ptr_q];

    assign ar_hs      = pcis_arvalid && pcis_arready;
    assign pop        = pcis_rvalid && pcis_rready;
    assign r_in_range = (rword_q[WAW-1:IDXW] == '0);
    // Occupancy net of the beat leaving this cycle keeps back-to-back beats flowing.
    assign occ   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (rd_state_q == RData) && (issue_cnt_q <= {1'b0, rlen_q}) && (occ < 3'd2);

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RIdle:   if (ar_hs) rd_state_d = RData;
            RData:   if (pop && fifo_last_q[rd_ptr_q]) rd_state_d = RIdle;
            default: rd_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_state_q      <= RIdle;
            rid_q           <= '0;
            rword_q         <= '0;
            rlen_q          <= '0;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_oor_q  <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            fifo_cnt_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_resp_q[i] <= RespOkay;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            rd_state_q <= rd_state_d;
            inflight_q <= issue;
            if (ar_hs) begin
                rid_q       <= pcis_arid;
                rword_q     <= pcis_araddr[63:ALSB];
                rlen_q      <= pcis_arlen;
                issue_cnt_q <= '0;
            end
            if (issue) begin
                rword_q         <= rword_q + WAW'(1);
                issue_cnt_q     <= issue_cnt_q + 9'd1;
                inflight_oor_q  <= !r_in_range;
                inflight_last_q <= (issue_cnt_q[7:0] == rlen_q);
            end
            if (inflight_q) begin
                fifo_resp_q[wr_ptr_q] <= inflight_oor_q ? RespSlverr : RespOkay;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (inflight_q) fifo_data_q[wr_ptr_q] <= inflight_oor_q ? '0 : ram_rdata;
    end

    awsf1_pcis_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (IDXW)
    ) u_bram (
        .clk   (clk_main_a0),
        .we    (w_hs && w_in_range),
        .waddr (wword_q[IDXW-1:0]),
        .wdata (pcis_wdata),
        .wstrb (pcis_wstrb),
        .re    (issue),
        .raddr (rword_q[IDXW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_awsf1_pcis_responder.sv
// Scoreboard bench for awsf1_pcis_responder: B and R beats checked against a memory model.
module tb_awsf1_pcis_responder;

    localparam int DW    = 512;
    localparam int IW    = 6;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IW-1:0]   awid, arid, bid, rid;
    logic [63:0]     awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready, perr;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;

    always #5 clk = ~clk;

    awsf1_pcis_responder #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .pcis_awid(awid), .pcis_awaddr(awaddr), .pcis_awlen(awlen),
        .pcis_awvalid(awvalid), .pcis_awready(awready),
        .pcis_wdata(wdata), .pcis_wstrb(wstrb), .pcis_wlast(wlast),
        .pcis_wvalid(wvalid), .pcis_wready(wready),
        .pcis_bid(bid), .pcis_bresp(bresp), .pcis_bvalid(bvalid), .pcis_bready(bready),
        .pcis_arid(arid), .pcis_araddr(araddr), .pcis_arlen(arlen),
        .pcis_arvalid(arvalid), .pcis_arready(arready),
        .pcis_rid(rid), .pcis_rdata(rdata), .pcis_rresp(rresp), .pcis_rlast(rlast),
        .pcis_rvalid(rvalid), .pcis_rready(rready),
        .protocol_err(perr)
    );

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t        exp_b[$];
    r_exp_t        exp_r[$];
    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_fail = 0;
    bit            rand_rr = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always begin
        @(posedge clk);
        #1;
        rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: pops scoreboard entries on handshakes, checks held beats while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    chk("b_resp", {bid, bresp}, {exp_b[0].id, exp_b[0].resp});
                    void'(exp_b.pop_front());
                end
            end
            if (rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    chk(rready ? "r_data" : "r_stall_data", rdata, exp_r[0].data);
                    chk(rready ? "r_ctl" : "r_stall_ctl", {rid, rresp, rlast},
                        {exp_r[0].id, exp_r[0].resp, exp_r[0].last});
                    if (rready) void'(exp_r.pop_front());
                end
            end
        end
    end

    function automatic logic rdy(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    // Entered at posedge+1 with valid driven; leaves at posedge+1 after the handshake edge.
    task automatic wait_rdy(input int which, input string tag);
        int t = 0;
        @(negedge clk);
        while (!rdy(which) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy(which)) chk(tag, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [63:0] addr, input int len);
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        wait_rdy(0, "aw_timeout");
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [57:0] word, input logic [DW/8-1:0] strb, input logic last,
                          output logic oor);
        logic [DW-1:0] d = rnd_word();
        wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
        wait_rdy(1, "w_timeout");
        wvalid = 1'b0; wlast = 1'b0;
        oor = (word >= 58'(DEPTH));
        if (!oor)
            for (int b = 0; b < DW / 8; b++)
                if (strb[b]) model[word[9:0]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [63:0] addr, input int len,
                            input logic [DW/8-1:0] strb, input int early);
        logic [1:0] resp = 2'b00;
        logic       oor;
        int         t = 0;
        aw_send(id, addr, len);
        for (int k = 0; k <= len; k++) begin
            w_beat(addr[63:6] + 58'(k), strb, (k == len) || (k == early), oor);
            if (oor) resp = 2'b10;
        end
        exp_b.push_back('{id: id, resp: resp});
        while (exp_b.size() != 0 && t < 100) begin
            cyc(1);
            t++;
        end
        if (exp_b.size() != 0) begin
            chk("b_timeout", 0, 1);
            exp_b.delete();
        end
    endtask

    task automatic rd_start(input logic [IW-1:0] id, input logic [63:0] addr, input int len);
        for (int k = 0; k <= len; k++) begin
            logic [57:0] w = addr[63:6] + 58'(k);
            if (w < 58'(DEPTH))
                exp_r.push_back('{id: id, data: model[w[9:0]], resp: 2'b00, last: (k == len)});
            else
                exp_r.push_back('{id: id, data: '0, resp: 2'b10, last: (k == len)});
        end
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        wait_rdy(2, "ar_timeout");
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [63:0] addr, input int len);
        int t = 0;
        rd_start(id, addr, len);
        while (exp_r.size() != 0 && t < 3000) begin
            cyc(1);
            t++;
        end
        if (exp_r.size() != 0) begin
            chk("r_timeout", 0, 1);
            exp_r.delete();
        end
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk(tag, {awready, wready, bvalid, arready, rvalid}, 0);
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        exp_r.delete();
        exp_b.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        logic oor;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, perr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_ready", {awready, arready, wready}, 3'b110);

        // Basic 4-beat write then read back
        do_write(6'h2a, 64'h40, 3, '1, -1);
        do_read(6'h15, 64'h40, 3);

        // Partial strobe on word 5
        do_write(6'h01, 64'd5 * 64, 0, '1, -1);
        do_write(6'h02, 64'd5 * 64, 0, 64'h1, -1);
        do_read(6'h03, 64'd5 * 64, 0);
        chk("perr_clean", perr, 0);

        // Straddle the top of the window: no wrap to word 0
        do_write(6'h04, 64'd0, 0, '1, -1);
        do_write(6'h05, 64'(DEPTH - 2) * 64, 3, '1, -1);
        do_read(6'h06, 64'(DEPTH - 2) * 64, 3);
        do_read(6'h07, 64'd0, 0);

        // Long read with random backpressure
        do_write(6'h08, 64'd200 * 64, 255, '1, -1);
        rand_rr = 1'b1;
        do_read(6'h09, 64'd200 * 64, 255);
        rand_rr = 1'b0;

        // Early wlast still takes all awlen+1 beats
        do_write(6'h0a, 64'd20 * 64, 3, '1, 1);
        chk("perr_set", perr, 1);
        do_read(6'h0b, 64'd20 * 64, 3);

        // Reset in the middle of an 8-beat write
        aw_send(6'h0c, 64'd600 * 64, 7);
        w_beat(58'd600, '1, 1'b0, oor);
        w_beat(58'd601, '1, 1'b0, oor);
        wdata = rnd_word(); wstrb = '1; wvalid = 1'b1;
        async_reset("rst_mid_write");
        chk("perr_cleared", perr, 0);
        do_read(6'h0d, 64'd600 * 64, 1);
        do_write(6'h0e, 64'd600 * 64, 7, '1, -1);
        do_read(6'h0f, 64'd600 * 64, 7);

        // Reset in the middle of a read
        rand_rr = 1'b1;
        rd_start(6'h10, 64'd200 * 64, 31);
        cyc(6);
        async_reset("rst_mid_read");
        rand_rr = 1'b0;
        do_read(6'h11, 64'd200 * 64, 15);
        do_read(6'h12, 64'd600 * 64, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
